traffic_timebase: RTL and testbench

//   Upstream timing front-end for the traffic-light controller. Divides the board clock

---
 rtl/traffic_timebase.sv | 144 ++++++++++++++
 tb/tb_traffic_timebase.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/traffic_timebase.sv
// Seconds tick, debounced clear request and optional blink for the traffic controller.
// Define TICK_BLINK_EN to add the blink square-wave output.
module traffic_timebase #(
    parameter int DIV    = 50_000_000,
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_in,
    output logic tick,
    output logic clr_req,
    output logic btn_level
`ifdef TICK_BLINK_EN
    ,
    output logic blink
`endif
);

    localparam int CW = $clog2(DIV);
    localparam int DW = $clog2(DB_CYC);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_WT = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_REL_WT   = 2'd3;

    logic          r_s0;
    logic          r_s1;
    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic [1:0]    r_state;
    logic [DW-1:0] r_dcnt;
    logic          r_req;
    logic          r_lvl;

    logic          w_cnt_wrap;
    logic          w_db_done;
    logic [1:0]    w_state_nx;
    logic [DW-1:0] w_dcnt_nx;
    logic          w_req_nx;
    logic          w_lvl_nx;

    assign w_cnt_wrap = (r_cnt == CW'(DIV - 1));
    assign w_db_done  = (r_dcnt == DW'(DB_CYC - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= btn_in;
            r_s1 <= r_s0;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_dcnt_nx  = r_dcnt + DW'(1);
        w_req_nx   = 1'b0;
        w_lvl_nx   = r_lvl;
        case (r_state)
            ST_IDLE: begin
                w_dcnt_nx = '0;
                if (r_s1) w_state_nx = ST_PRESS_WT;
            end
            ST_PRESS_WT: begin
                if (!r_s1) begin
                    w_state_nx = ST_IDLE;
                    w_dcnt_nx  = '0;
                end else if (w_db_done) begin
                    w_state_nx = ST_PRESSED;
                    w_dcnt_nx  = '0;
                    w_req_nx   = 1'b1;
                    w_lvl_nx   = 1'b1;
                end
            end
            ST_PRESSED: begin
                w_dcnt_nx = '0;
                if (!r_s1) w_state_nx = ST_REL_WT;
            end
            ST_REL_WT: begin
                if (r_s1) begin
                    w_state_nx = ST_PRESSED;
                    w_dcnt_nx  = '0;
                end else if (w_db_done) begin
                    w_state_nx = ST_IDLE;
                    w_dcnt_nx  = '0;
                    w_lvl_nx   = 1'b0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_dcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
            r_req   <= 1'b0;
            r_lvl   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_dcnt  <= w_dcnt_nx;
            r_req   <= w_req_nx;
            r_lvl   <= w_lvl_nx;
        end
    end

    // An accepted press realigns the timebase and beats a coincident wrap.
    always_ff @(posedge clk) begin
        if (clr || w_req_nx) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_cnt_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

`ifdef TICK_BLINK_EN
    logic r_blink;

    always_ff @(posedge clk) begin
        if (clr || w_req_nx) begin
            r_blink <= 1'b0;
        end else if (w_cnt_wrap) begin
            r_blink <= ~r_blink;
        end
    end

    assign blink = r_blink;
`endif

    assign tick      = r_tick;
    assign clr_req   = r_req;
    assign btn_level = r_lvl;

endmodule

// File: tb/tb_traffic_timebase.sv
// Bench for traffic_timebase with DIV=10, DB_CYC=4.
// Edge c counts rising edges after the last clr edge; pat bit c is btn_in sampled at edge c.
module tb_traffic_timebase;

    localparam int DIV = 10;
    localparam int DB  = 4;

    logic clk    = 1'b0;
    logic clr    = 1'b1;
    logic btn_in = 1'b0;
    logic tick;
    logic clr_req;
    logic btn_level;
`ifdef TICK_BLINK_EN
    logic blink;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_timebase #(
        .DIV    (DIV),
        .DB_CYC (DB)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_in    (btn_in),
        .tick      (tick),
        .clr_req   (clr_req),
        .btn_level (btn_level)
`ifdef TICK_BLINK_EN
        ,
        .blink     (blink)
`endif
    );

    typedef struct {
        string       name;
        int          rst_len;
        logic [63:0] pat;
        int          cycles;
        int          req_at;
        int          rel_at;
    } vec_t;

    typedef struct {
        int   cyc;
        logic tk;
        logic rq;
        logic lv;
        logic bk;
    } exp_t;

    vec_t vt[7];
    exp_t sb[$];

    task automatic chk(input string nm, input int c, input logic act,
                       input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, c, act, exp);
        end
    endtask

    task automatic do_reset(input int n, input logic b);
        clr    = 1'b1;
        btn_in = b;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("rst_tick", k, tick, 1'b0);
            chk("rst_req", k, clr_req, 1'b0);
            chk("rst_lvl", k, btn_level, 1'b0);
`ifdef TICK_BLINK_EN
            chk("rst_blink", k, blink, 1'b0);
`endif
        end
        clr = 1'b0;
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic bexp;
        int   base;
        int   got;
        int   extra;

        vt[0] = '{"free", 3, 64'h0, 32, -1, -1};
        vt[1] = '{"hold", 3, 64'h0, 40, 9, 29};
        vt[1].pat = ((64'd1 << 23) - 64'd1) & ~((64'd1 << 3) - 64'd1);
        vt[2] = '{"bounce", 3, 64'h198, 20, -1, -1};
        vt[3] = '{"coinc", 3, ~64'hF, 35, 10, -1};
        vt[4] = '{"hold_clr", 1, '1, 25, 7, -1};
        vt[5] = '{"short", 3, 64'h1E, 20, -1, -1};
        vt[6] = '{"minimum", 3, 64'h3E, 20, 7, 12};

        for (int i = 0; i < 7; i++) begin
            v = vt[i];
            do_reset(v.rst_len, v.pat[0]);
            bexp = 1'b0;
            for (int c = 1; c <= v.cycles; c++) begin
                base  = (v.req_at >= 0 && c >= v.req_at) ? v.req_at : 0;
                e.cyc = c;
                e.tk  = (c > base) && ((c - base) % DIV == 0);
                e.rq  = (c == v.req_at);
                e.lv  = (v.req_at >= 0) && (c >= v.req_at) &&
                        (v.rel_at < 0 || c < v.rel_at);
                if (e.rq) bexp = 1'b0;
                else if (e.tk) bexp = ~bexp;
                e.bk  = bexp;
                sb.push_back(e);
                btn_in = v.pat[c];
                @(posedge clk);
                #1;
                e = sb.pop_front();
                chk({v.name, ".tick"}, e.cyc, tick, e.tk);
                chk({v.name, ".req"}, e.cyc, clr_req, e.rq);
                chk({v.name, ".lvl"}, e.cyc, btn_level, e.lv);
`ifdef TICK_BLINK_EN
                chk({v.name, ".blink"}, e.cyc, blink, e.bk);
`endif
            end
        end

        // clr lands mid-debounce; the press must be requalified from scratch
        do_reset(2, 1'b0);
        btn_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_clr_req", 0, clr_req, 1'b0);
        chk("mid_clr_lvl", 0, btn_level, 1'b0);
        clr = 1'b0;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (clr_req) begin
                got = k;
                break;
            end
        end
        total++;
        if (got == 0) begin
            bad++;
            $display("FAIL mid_timeout got=none want=7");
        end else if (got != 7) begin
            bad++;
            $display("FAIL mid_latency got=%0d want=7", got);
        end
        chk("mid_lvl", got, btn_level, 1'b1);
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (clr_req) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL mid_repeat got=%0d want=0", extra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
